// File: rtl/inst_loader_pkg.sv
// Shared types and helpers for the serial instruction-memory loader.
package inst_loader_pkg;

    // Protocol framing states
    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM
    } load_state_t;

    // 8N1 receive states
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Clocks per serial bit, integer-truncated
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/inst_loader_rx.sv
// Two-flop synchroniser plus 8N1 byte receiver with start-bit glitch rejection.
module uart_rx_byte
    import inst_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       shift, shift_n;
    logic             valid_n, err_n;

    // Bring the asynchronous line into the clock domain; resets to idle-high
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers take <= so every flop samples pre-edge values, whatever the statement order.
        if (!reset) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], uart_rx};
    end

    assign rx_s      = sync_q[1];
    assign byte_data = shift;

    // Receiver state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shift      <= shift_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    // Bit timing: mid-start re-check, then one sample per bit period
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        valid_n = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    valid_n = rx_s;
                    err_n   = !rx_s;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/inst_loader.sv
// Serial program loader: frames bytes into words, writes instruction memory, gates CPU reset.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned BAUD           = 115_200,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned MAX_WORDS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             byte_valid, frame_err;
    logic [7:0]       byte_data;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    load_state_t       state, state_n;
    logic [7:0]        n_words, n_words_n;
    logic [7:0]        word_cnt, word_cnt_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [23:0]       word_lo, word_lo_n;
    logic [7:0]        sum, sum_n;
    logic              im_we_n, cpu_hold_n, load_done_n, load_err_n;
    logic [ADDR_W-1:0] im_addr_n;
    logic [31:0]       im_wdata_n;
    logic              abort;

    uart_rx_byte #(
        .CLKS_PER_BIT(clks_per_bit(CLK_FREQ_HZ, BAUD))
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign busy    = (state != WAIT_SYNC);
    assign tmo_hit = busy && !byte_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Saturating idle-line counter inside a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       tmo_cnt <= '0;
        else if (byte_valid || !busy)     tmo_cnt <= '0;
        else if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Protocol state, word assembly and registered write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_SYNC;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word_lo   <= '0;
            sum       <= '0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_n;
            n_words   <= n_words_n;
            word_cnt  <= word_cnt_n;
            byte_cnt  <= byte_cnt_n;
            word_lo   <= word_lo_n;
            sum       <= sum_n;
            im_we     <= im_we_n;
            im_addr   <= im_addr_n;
            im_wdata  <= im_wdata_n;
            cpu_hold  <= cpu_hold_n;
            load_done <= load_done_n;
            load_err  <= load_err_n;
        end
    end

    // Next-state: the write strobe cycle stays in GET_DATA and advances the word index
    always_comb begin
        state_n     = state;
        n_words_n   = n_words;
        word_cnt_n  = word_cnt;
        byte_cnt_n  = byte_cnt;
        word_lo_n   = word_lo;
        sum_n       = sum;
        im_we_n     = 1'b0;
        im_addr_n   = im_addr;
        im_wdata_n  = im_wdata;
        cpu_hold_n  = cpu_hold;
        load_done_n = load_done;
        load_err_n  = load_err;
        abort       = busy && (frame_err || tmo_hit);
        unique case (state)
            WAIT_SYNC: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    load_done_n = 1'b0;
                    load_err_n  = 1'b0;
                    cpu_hold_n  = 1'b1;
                    state_n     = GET_LEN;
                end
            end
            GET_LEN: begin
                if (byte_valid) begin
                    if (byte_data == 8'd0 || 32'(byte_data) > MAX_WORDS) begin
                        abort = 1'b1;
                    end else begin
                        n_words_n  = byte_data;
                        word_cnt_n = '0;
                        byte_cnt_n = '0;
                        sum_n      = '0;
                        state_n    = GET_DATA;
                    end
                end
            end
            GET_DATA: begin
                if (im_we) begin
                    word_cnt_n = word_cnt + 8'd1;
                    if (word_cnt == n_words - 8'd1) state_n = GET_SUM;
                end else if (byte_valid) begin
                    word_lo_n  = {byte_data, word_lo[23:8]};
                    sum_n      = sum + byte_data;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        im_we_n    = 1'b1;
                        im_addr_n  = ADDR_W'({word_cnt, 2'b00});
                        im_wdata_n = {byte_data, word_lo};
                    end
                end
            end
            GET_SUM: begin
                if (byte_valid) begin
                    if (byte_data == sum) begin
                        load_done_n = 1'b1;
                        cpu_hold_n  = 1'b0;
                        state_n     = WAIT_SYNC;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            default: state_n = WAIT_SYNC;
        endcase
        // Abort leaves cpu_hold set so a partial image never runs
        if (abort) begin
            load_err_n = 1'b1;
            im_we_n    = 1'b0;
            state_n    = WAIT_SYNC;
        end
    end

endmodule
